// File: rtl/darkwbuf_pkg.sv
// Shared types and widths for the darkwbuf posted-write buffer.
// Entry layout and FSM encoding live here so the FIFO and top agree.
package darkwbuf_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } wbuf_state_t;

endpackage

// File: rtl/darkbus.sv
// darkbus: simple request/valid data bus with a shared bidirectional data lane.
// The producer drives the request; the consumer answers with valid.
interface darkbus;
  logic [31:0] addr;
  wire  [31:0] data;
  logic        rw;
  logic [3:0]  be;
  logic        en;
  logic        valid;

  modport prod (output addr, inout data, output rw, output be, output en, input valid);
  modport cons (input addr, inout data, input rw, input be, input en, output valid);
endinterface

// File: rtl/darkfifo.sv
// Synchronous FIFO with a combinational head output.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module darkfifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [67:0]
) (
  input  logic                   XCLK,
  input  logic                   XRES,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  T                       i_din,
  output T                       o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= PW'(r_rd_ptr + 1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge XCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/darkwbuf.sv
// Posted-write buffer: stores post into a FIFO and drain in order; loads wait
// for an empty buffer so they always observe every earlier store.
//   state | meaning
//   IDLE  | no RAM access; start a drain if anything is buffered, else serve a load
//   WRITE | head entry presented to the RAM until it answers valid
//   READ  | load passed through to the RAM, response returned to the core
module darkwbuf
  import darkwbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic XCLK,
  input  logic XRES,
  darkbus.cons CPU,
  darkbus.prod MEM,
  output logic WBEMPTY
);
  localparam int CW = $clog2(DEPTH) + 1;

  wbuf_state_t r_state;
  wbuf_entry_t w_din;
  wbuf_entry_t w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  // Everything facing the buses is forced quiet while reset is held.
  assign w_wr   = (r_state == WRITE) & ~XRES;
  assign w_rd   = (r_state == READ) & ~XRES;
  assign w_push = CPU.en & CPU.rw & ~w_full & ~XRES & (r_state != READ);
  assign w_pop  = w_wr & MEM.valid;

  assign w_din = '{addr: CPU.addr, data: CPU.data, be: CPU.be};

  darkfifo #(
    .DEPTH(DEPTH),
    .T    (wbuf_entry_t)
  ) u_fifo (
    .XCLK   (XCLK),
    .XRES   (XRES),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_din),
    .o_dout (w_head),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count != '0)             r_state <= WRITE;
          else if (CPU.en && !CPU.rw)    r_state <= READ;
        end
        WRITE: begin
          if (w_count_after == '0)       r_state <= IDLE;
        end
        READ: begin
          if (!CPU.en || MEM.valid)      r_state <= IDLE;
        end
        default:                         r_state <= IDLE;
      endcase
    end
  end

  assign MEM.en   = w_wr | w_rd;
  assign MEM.rw   = w_wr;
  assign MEM.addr = w_wr ? w_head.addr : CPU.addr;
  assign MEM.be   = w_wr ? w_head.be   : CPU.be;
  assign MEM.data = w_wr ? w_head.data : 'z;

  assign CPU.data  = w_rd ? MEM.data : 'z;
  assign CPU.valid = w_rd ? (MEM.valid & CPU.en) : w_push;

  assign WBEMPTY = XRES | (w_empty & (r_state == IDLE));
endmodule

// File: tb/tb_darkwbuf.sv
// Bench for darkwbuf: table of store/load vectors plus hand-written multi-cycle
// sequences; RAM writes are checked in order against a scoreboard queue.
module tb_darkwbuf;
  import darkwbuf_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wbempty;
  always #5 clk = ~clk;

  darkbus cpu_bus ();
  darkbus mem_bus ();

  darkwbuf #(.DEPTH(DEPTH)) dut (
    .XCLK   (clk),
    .XRES   (rst),
    .CPU    (cpu_bus),
    .MEM    (mem_bus),
    .WBEMPTY(wbempty)
  );

  int checks = 0;
  int errors = 0;

  // Core model
  logic [31:0] c_wdata = '0;
  assign cpu_bus.data = (cpu_bus.en && cpu_bus.rw) ? c_wdata : 'z;

  // RAM model with configurable wait states
  logic [31:0] ram [256];
  int ram_wait   = 0;
  bit ram_hold   = 1'b0;
  int ram_wcnt   = 0;
  int ram_wr_cnt = 0;
  wbuf_entry_t sb[$];

  assign mem_bus.valid = mem_bus.en && !ram_hold && (ram_wcnt >= ram_wait);
  assign mem_bus.data  = (mem_bus.en && !mem_bus.rw) ? ram[mem_bus.addr[9:2]] : 'z;

  always @(posedge clk) begin
    if (mem_bus.en && !mem_bus.valid) ram_wcnt <= ram_wcnt + 1;
    else                              ram_wcnt <= 0;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [3:0]  m;
    logic [31:0] r;
    m = (be == 4'h0) ? 4'hF : be;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    wbuf_entry_t e;
    if (mem_bus.en && mem_bus.valid && mem_bus.rw) begin
      ram_wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected addr=%h data=%h be=%h", mem_bus.addr, mem_bus.data, mem_bus.be);
      end else begin
        e = sb.pop_front();
        if (mem_bus.addr !== e.addr || mem_bus.data !== e.data || mem_bus.be !== e.be) begin
          errors++;
          $display("FAIL ram_write_order got %h/%h/%h want %h/%h/%h",
                   mem_bus.addr, mem_bus.data, mem_bus.be, e.addr, e.data, e.be);
        end
      end
      ram[mem_bus.addr[9:2]] = merge(ram[mem_bus.addr[9:2]], mem_bus.data, mem_bus.be);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int budget, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    cpu_bus.en = 1'b1; cpu_bus.rw = 1'b1; cpu_bus.addr = a; cpu_bus.be = be; c_wdata = d;
    while (!done) begin
      @(negedge clk);
      if (cpu_bus.valid) begin
        sb.push_back('{addr: a, data: d, be: be});
        done = 1'b1;
      end else if (waited >= budget) begin
        checks++; errors++;
        $display("FAIL store_timeout addr=%h waited=%0d budget=%0d", a, waited, budget);
        done = 1'b1;
      end else begin
        waited++;
      end
      next_cyc();
    end
    cpu_bus.en = 1'b0; cpu_bus.rw = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input int budget,
                         output logic [31:0] d, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    d = '0;
    cpu_bus.en = 1'b1; cpu_bus.rw = 1'b0; cpu_bus.addr = a; cpu_bus.be = 4'hF;
    while (!done) begin
      @(negedge clk);
      if (cpu_bus.valid) begin
        d = cpu_bus.data;
        done = 1'b1;
      end else if (waited >= budget) begin
        checks++; errors++;
        $display("FAIL load_timeout addr=%h waited=%0d", a, waited);
        done = 1'b1;
      end else begin
        waited++;
      end
      next_cyc();
    end
    cpu_bus.en = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!wbempty && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, wbempty}, 32'd1);
    next_cyc();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int w;
    int base;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h14, 32'h11223344, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 32'h14, 32'h0,        4'hF, 32'h11223344};
    vecs[4]  = '{1'b1, 32'h14, 32'hFFFFFFFF, 4'h4, 32'h0};
    vecs[5]  = '{1'b0, 32'h14, 32'h0,        4'hF, 32'h11FF3344};
    vecs[6]  = '{1'b1, 32'h18, 32'hCAFEF00D, 4'h8, 32'h0};
    vecs[7]  = '{1'b0, 32'h18, 32'h0,        4'hF, 32'hCA000000};
    vecs[8]  = '{1'b0, 32'h1C, 32'h0,        4'hF, 32'h00000000};
    vecs[9]  = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0};
    vecs[10] = '{1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEAA};

    for (int i = 0; i < 256; i++) ram[i] = '0;
    cpu_bus.en = 1'b0; cpu_bus.rw = 1'b0; cpu_bus.addr = '0; cpu_bus.be = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_mem_en", {31'd0, mem_bus.en}, 32'd0);
      check("rst_cpu_valid", {31'd0, cpu_bus.valid}, 32'd0);
      check("rst_wbempty", {31'd0, wbempty}, 32'd1);
    end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_en", {31'd0, mem_bus.en}, 32'd0);
    check("post_rst_wbempty", {31'd0, wbempty}, 32'd1);
    next_cyc();

    // Single store, zero-wait RAM: exact cycle-by-cycle drain
    cpu_bus.en = 1'b1; cpu_bus.rw = 1'b1; cpu_bus.addr = 32'h10; cpu_bus.be = 4'hF;
    c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("st0_valid", {31'd0, cpu_bus.valid}, 32'd1);
    if (cpu_bus.valid) sb.push_back('{addr: 32'h10, data: 32'hDEADBEEF, be: 4'hF});
    next_cyc();
    cpu_bus.en = 1'b0; cpu_bus.rw = 1'b0;
    @(negedge clk);
    check("st1_mem_en", {31'd0, mem_bus.en}, 32'd0);
    check("st1_wbempty", {31'd0, wbempty}, 32'd0);
    next_cyc();
    @(negedge clk);
    check("st2_mem_en", {31'd0, mem_bus.en}, 32'd1);
    check("st2_mem_rw", {31'd0, mem_bus.rw}, 32'd1);
    check("st2_mem_addr", mem_bus.addr, 32'h10);
    check("st2_mem_data", mem_bus.data, 32'hDEADBEEF);
    next_cyc();
    @(negedge clk);
    check("st3_wbempty", {31'd0, wbempty}, 32'd1);
    check("st3_mem_en", {31'd0, mem_bus.en}, 32'd0);
    next_cyc();

    // Table-driven stores and loads
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) begin
        do_store(vecs[i].addr, vecs[i].data, vecs[i].be, 0, w);
        check($sformatf("vec%0d_store_wait", i), w, 0);
      end else begin
        do_load(vecs[i].addr, 40, d, w);
        check($sformatf("vec%0d_load_data", i), d, vecs[i].exp);
      end
    end
    wait_empty("vec_drain", 40);

    // Load from an empty buffer: exactly one stall cycle
    do_load(32'h10, 10, d, w);
    check("load_empty_stall", w, 1);
    check("load_empty_data", d, 32'hDEADBEAA);

    // Fill to full with the RAM stalled
    ram_hold = 1'b1;
    base = ram_wr_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      do_store(32'h80 + 32'(4*i), 32'hF0000000 + 32'(i), 4'hF, 0, w);
      check($sformatf("fill%0d_wait", i), w, 0);
    end
    cpu_bus.en = 1'b1; cpu_bus.rw = 1'b1; cpu_bus.addr = 32'h90; cpu_bus.be = 4'hF;
    c_wdata = 32'hF0000004;
    repeat (3) begin
      @(negedge clk);
      check("full_blocked", {31'd0, cpu_bus.valid}, 32'd0);
      next_cyc();
    end
    ram_hold = 1'b0;
    w = 0;
    @(negedge clk);
    while (!cpu_bus.valid && w < 20) begin
      next_cyc();
      @(negedge clk);
      w++;
    end
    check("full_release_wait", w, 1);
    if (cpu_bus.valid) sb.push_back('{addr: 32'h90, data: 32'hF0000004, be: 4'hF});
    next_cyc();
    cpu_bus.en = 1'b0; cpu_bus.rw = 1'b0;
    wait_empty("fill_drain", 40);
    check("fill_write_count", ram_wr_cnt - base, 5);
    check("fill_sb_empty", sb.size(), 0);

    // Read-after-write with a partial byte enable
    ram[32'h20 >> 2] = 32'hAAAAAAAA;
    do_store(32'h20, 32'h12345678, 4'h3, 0, w);
    do_load(32'h20, 40, d, w);
    check("raw_data", d, 32'hAAAA5678);
    check("raw_stall_min", {31'd0, (w >= 3)}, 32'd1);

    // Sustained push+pop at count 2 over several pointer laps
    base = ram_wr_cnt;
    for (int i = 0; i < 14; i++) begin
      do_store(32'h100 + 32'(4*i), 32'hA5000000 + 32'(i), 4'hF, 0, w);
      check($sformatf("pp%0d_wait", i), w, 0);
      if (i >= 1) check($sformatf("pp%0d_count", i), 32'(dut.w_count), 32'd2);
    end
    wait_empty("pp_drain", 40);
    check("pp_write_count", ram_wr_cnt - base, 14);
    check("pp_sb_empty", sb.size(), 0);

    // Reset in the middle of a drain
    ram_wait = 1;
    base = ram_wr_cnt;
    for (int i = 0; i < 3; i++) do_store(32'h200 + 32'(4*i), 32'h5EED0000 + 32'(i), 4'hF, 0, w);
    check("rmd_in_write", {31'd0, mem_bus.en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rmd_en_in_rst", {31'd0, mem_bus.en}, 32'd0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rmd_en_after", {31'd0, mem_bus.en}, 32'd0);
    check("rmd_wbempty", {31'd0, wbempty}, 32'd1);
    repeat (10) next_cyc();
    check("rmd_no_writes", ram_wr_cnt - base, 0);
    sb.delete();
    ram_wait = 0;

    // Load with a 2-cycle RAM wait
    ram_wait = 2;
    ram[32'h40 >> 2] = 32'h5A5A1234;
    cpu_bus.en = 1'b1; cpu_bus.rw = 1'b0; cpu_bus.addr = 32'h40; cpu_bus.be = 4'hF;
    @(negedge clk);
    check("rw2_c0_en", {31'd0, mem_bus.en}, 32'd0);
    check("rw2_c0_valid", {31'd0, cpu_bus.valid}, 32'd0);
    next_cyc();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("rw2_c%0d_en", c), {31'd0, mem_bus.en}, 32'd1);
      check($sformatf("rw2_c%0d_addr", c), mem_bus.addr, 32'h40);
      check($sformatf("rw2_c%0d_valid", c), {31'd0, cpu_bus.valid}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) check("rw2_data", cpu_bus.data, 32'h5A5A1234);
      next_cyc();
    end
    cpu_bus.en = 1'b0;
    @(negedge clk);
    check("rw2_done_en", {31'd0, mem_bus.en}, 32'd0);
    next_cyc();
    ram_wait = 0;

    // Abandoned load
    ram_hold = 1'b1;
    cpu_bus.en = 1'b1; cpu_bus.rw = 1'b0; cpu_bus.addr = 32'h44;
    next_cyc();
    @(negedge clk);
    check("abn_read_en", {31'd0, mem_bus.en}, 32'd1);
    next_cyc();
    cpu_bus.en = 1'b0;
    @(negedge clk);
    check("abn_no_valid", {31'd0, cpu_bus.valid}, 32'd0);
    next_cyc();
    @(negedge clk);
    check("abn_idle_en", {31'd0, mem_bus.en}, 32'd0);
    check("abn_wbempty", {31'd0, wbempty}, 32'd1);
    next_cyc();
    ram_hold = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/darkwbuf.md
# darkwbuf

Posted-write buffer between the core data port and the data RAM. Core stores are accepted in one cycle into a DEPTH-entry FIFO and drained to the RAM in order. Core loads stall until the FIFO is drained, then pass through to the RAM, so every load observes all earlier stores. Sits directly upstream of the data RAM slave on the darkbus.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.

Ports (clock and reset first):
- XCLK  input  1  clock; one clock domain, all state updates on the rising edge.
- XRES  input  1  reset; synchronous, active-high.
- CPU  darkbus.cons  bundle  core-facing side; the block consumes addr[31:0], data[31:0] (bidirectional), rw (1 = write), be[3:0], en; it drives valid.
- MEM  darkbus.prod  bundle  RAM-facing side; the block drives addr, data (on writes), rw, be, en; it consumes data (on reads) and valid.
- WBEMPTY  output  1  1 when count == 0 and state is IDLE; used for I/O ordering and fences.

## Operation
- FIFO entry holds {addr[31:0], data[31:0], be[3:0]}. count is in 0..DEPTH, with $clog2(DEPTH)+1 bits. rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Store accept: CPU.en & CPU.rw & (count < DEPTH) → CPU.valid=1 combinationally in the same cycle; the entry is pushed at the clock edge.
  - When full, CPU.valid=0 and the core holds its request.
  - be is stored and forwarded unchanged; be==0 is passed to the RAM as-is, where it means a full-word write.
- FSM with states IDLE, WRITE, READ; encoding lives in the package.
- IDLE:
  - MEM.en=0.
  - If count>0 → WRITE.
  - Else if CPU.en & !CPU.rw → READ.
  - A load pending while count>0 gets CPU.valid=0; drain has priority.
- WRITE:
  - MEM.en=1, MEM.rw=1; MEM.addr/data/be are taken from the head entry.
  - On MEM.valid the head is popped. Stay in WRITE if count after the pop (including any same-cycle push) is >0, else → IDLE.
  - Outputs are held stable until MEM.valid.
- READ:
  - MEM.en=1, MEM.rw=0, MEM.addr=CPU.addr, MEM.be=CPU.be.
  - CPU.data is driven from MEM.data; CPU.valid=MEM.valid.
  - On MEM.valid → IDLE.
  - If CPU.en drops while in READ (abandoned request), → IDLE without asserting CPU.valid.
- Data-bus drive rules:
  - MEM.data is driven only in WRITE; otherwise Z.
  - CPU.data is driven only in READ; otherwise Z.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. A push when count==DEPTH is blocked even if a pop occurs in that cycle.
- Stores issued during READ are impossible, since the core is stalled. Stores issued during WRITE are accepted if not full.

## Timing
- Reset values while XRES=1 and in the cycle after: state=IDLE, count=0, pointers=0, MEM.en=0, CPU.valid=0, MEM.data/CPU.data=Z, WBEMPTY=1.
- Reset mid-operation discards all buffered stores and aborts any RAM access in flight.
- Store latency at the core: 0 wait cycles when not full.
- Drain timing with a zero-wait RAM (MEM.valid=MEM.en):
  - Store pushed in cycle N, count=1 in N+1, WRITE in N+2, pop at the end of N+2.
  - Back-to-back entries then drain at one per cycle.
- Load with empty buffer and IDLE in cycle N: READ in N+1, CPU.valid=1 in N+1 with a zero-wait RAM (1 stall cycle).
- Load behind k buffered stores: CPU.valid no earlier than k+1 cycles after the drain starts.
- RAM wait states extend WRITE/READ indefinitely; there is no timeout.

## Structure
- Package darkwbuf_pkg:
  - wbuf_entry_t packed struct {addr, data, be}.
  - wbuf_state_t enum {IDLE, WRITE, READ}.
  - Width constants: ADDR_W=32, DATA_W=32, BE_W=4.
- Sub-module darkfifo: synchronous FIFO parameterised on DEPTH and entry type.
  - Ports: push, pop, din, dout (head, combinational), count, full, empty.
  - Reset: XRES, synchronous.
- darkwbuf holds the FSM, bus muxing, tri-state control and WBEMPTY.

## Test plan
- Single store, zero-wait RAM: write addr 0x10, data 0xDEADBEEF, be 0xF at cycle 0 → CPU.valid=1 in cycle 0, MEM write of 0xDEADBEEF to 0x10 in cycle 2, WBEMPTY=1 in cycle 3.
- Fill to full: 5 consecutive stores with DEPTH=4 and the RAM holding MEM.valid=0 → first 4 accepted, 5th sees CPU.valid=0 until the first MEM.valid. The RAM then receives all 5 in issue order.
- Read-after-write: store 0x12345678 to 0x20 with be 0x3, then load 0x20 (RAM previously 0xAAAAAAAA) → load stalls until the store drains and returns 0xAAAA5678.
- Simultaneous push/pop at count=2 during WRITE with MEM.valid=1 → count stays 2, pointers wrap correctly across ≥3 full laps, no entry lost or duplicated.
- Reset mid-drain: 3 stores buffered, XRES=1 for one cycle while in WRITE → next cycle MEM.en=0, WBEMPTY=1, none of the remaining stores reach the RAM.
- Read with 2-cycle RAM wait: empty buffer, load 0x40 → MEM.en held with stable addr for 3 cycles, CPU.valid only in the cycle MEM.valid=1, CPU.data=Z outside READ.
